gpio_irq_port: RTL and testbench
================================

# gpio_irq_port

Parametrised Wishbone GPIO and external-interrupt controller for the URduino SoC peripheral bus, successor to the fixed 32-pin port. It provides:
- N_PINS bidirectional pads with per-pin direction.
- Atomic set/clear of output bits.
- Synchronised input sampling.
- Per-pin interrupt detection, selectable as low-level, any-edge, falling or rising.
- Write-1-to-clear flags and a single level interrupt line to the CPU.

## Interface
- N_PINS, 32, number of pads, 1..32; register bits at and above N_PINS read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth, 2..4.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_addr_i  in  32  byte address; only [5:2] decoded, upper bits ignored (interconnect decodes base).
- wb_sel_i  in  4  byte enables for writes.
- wb_data_i  in  32  write data.
- wb_data_o  out  32  registered read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- gpio_io  inout  N_PINS  pads; driven with OUT[i] when DIR[i]=1, else high-Z.
- int_o  out  1  registered interrupt request, level, active-high.

## Operation
- Register map, by word offset wb_addr_i[5:2]:
  - 0 DIR, RW, 1 = output.
  - 1 OUT, RW.
  - 2 IN, RO; synchronised pad value, including pins driven as outputs.
  - 3 SET, WO; OUT |= data.
  - 4 CLR, WO; OUT &= ~data.
  - 5 MODE_LO, RW; 2 bits per pin, pins 0-15.
  - 6 MODE_HI, RW; pins 16-31.
  - 7 IMASK, RW.
  - 8 IFLAG, RW1C.
  - 9..15 reserved: read 0, writes ignored, still acked.
- Write-only registers read 0.
- Byte lanes: wb_sel_i gates writes to DIR, OUT, SET, CLR, MODE_*, IMASK and IFLAG clear, per byte.
- MODE encoding per pin:
  - 00: low level; flag set every cycle the synced input is 0.
  - 01: any edge.
  - 10: falling edge.
  - 11: rising edge.
- Edge detection compares the synced input with its value one cycle earlier (register prev).
- Flags are set regardless of IMASK. int_o is the registered value of |(IFLAG & IMASK).
- Simultaneous detection and W1C clear of the same bit in the same cycle: set wins; the flag stays 1.
- Warm-up counter: after reset, edge detection is suppressed until the counter reaches SYNC_STAGES+1 cycles. This prevents a spurious edge from a pad that is already high. Level mode is not suppressed.
- Bus handshake:
  - request = wb_cyc_i & wb_stb_i.
  - Ack is registered as request & ~wb_ack_o: one ack pulse per access, and at most one ack every two cycles while request is held.
  - The write takes effect, and wb_data_o is loaded, on the same clock edge that raises wb_ack_o.
  - Dropping the request before ack aborts the access with no side effect.
- Reset values:
  - DIR, OUT, MODE, IMASK, IFLAG = 0; all pads inputs.
  - Synchroniser, prev and warm-up counter = 0.
  - wb_ack_o = 0, wb_data_o = 0, int_o = 0.
- Reset mid-transaction: ack and all state clear immediately, asynchronously; the in-flight write is lost.

## Timing
- Read and write latency: wb_ack_o high 1 cycle after request is first sampled, for exactly 1 cycle.
- Pad to IN: SYNC_STAGES edges.
- Pad edge to IFLAG: SYNC_STAGES+1 edges.
- IFLAG to int_o: 1 further edge.
- W1C of the last masked flag: int_o falls 1 cycle after the write edge.
- DIR/OUT write to pad drive: combinational from the register, visible the cycle after the ack edge.
- SET/CLR are single-cycle read-modify-write: no lost bits, no glitch on untouched bits.

## Test plan
- Reset values: assert rst_i mid-write, then release -> all registers read 0, gpio_io all Z, int_o=0, wb_ack_o=0.
- Output drive:
  - Write DIR=0x0000_00FF, then OUT=0x0000_00A5 -> pads[7:0]=0xA5, pads[31:8]=Z.
  - SET 0x0F -> OUT=0xAF.
  - CLR 0xA0 -> OUT=0x0F.
  - Write OUT with sel=4'b0001 and data 0xFFFF_FF00 -> OUT=0x00.
- Rising edge: MODE_LO pin3=11, IMASK=0x8; drive pad3 0->1 -> IFLAG=0x8 after 3 cycles, int_o=1 the cycle after; W1C 0x8 -> int_o=0 one cycle later.
- Level/race: MODE pin0=00, pad0 held low, W1C IFLAG bit0 -> bit remains 1 (set wins) and int_o stays high while unmasked; IMASK=0 -> int_o=0.
- Warm-up: hold pad5 high through reset with MODE pin5=11 -> IFLAG stays 0; a later 1->0->1 sequence sets bit5.
- Handshake: hold stb/cyc for 6 cycles on a read -> ack pulses at cycles 1, 3, 5; a reserved address (offset 12) reads 0; N_PINS=8 build: DIR write 0xFFFF_FFFF reads back 0x0000_00FF.

Source files
------------

// File: rtl/gpio_irq_port.sv
// Wishbone GPIO port with per-pin direction, atomic set/clear, synchronised inputs
// and per-pin level/edge interrupt flags combined into one registered request line.
module gpio_irq_port #(
    parameter int N_PINS      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_addr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_data_i,
    output logic [31:0]       wb_data_o,
    output logic              wb_ack_o,
    inout  wire  [N_PINS-1:0] gpio_io,
    output logic              int_o
);

    function automatic logic [31:0] lsb_ones(input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) if (i < n) r[i] = 1'b1;
        return r;
    endfunction

    localparam logic [31:0] PIN_MASK  = lsb_ones(N_PINS);
    localparam logic [31:0] MLO_MASK  = lsb_ones(2 * N_PINS);
    localparam logic [31:0] MHI_MASK  = lsb_ones(2 * N_PINS - 32);
    localparam logic [2:0]  WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_q, sync_d;
    logic [31:0] dir_q, dir_d, out_q, out_d, mode_lo_q, mode_lo_d, mode_hi_q, mode_hi_d;
    logic [31:0] imask_q, imask_d, iflag_q, iflag_d, prev_q, prev_d, rdata_q, rdata_d;
    logic [2:0]  warm_q, warm_d;
    logic        ack_q, ack_d, int_q, int_d;

    logic [31:0] in_w, wm, wdat, rdata, det, w1c, rise, fall;
    logic [63:0] mode_all;
    logic        wr, warm;
    logic        unused_addr;

    assign unused_addr = ^{wb_addr_i[31:6], wb_addr_i[1:0]};
    assign in_w        = 32'(sync_q[SYNC_STAGES-1]);
    assign mode_all    = {mode_hi_q, mode_lo_q};
    assign warm        = (warm_q == WARM_DONE);
    assign rise        = in_w & ~prev_q;
    assign fall        = ~in_w & prev_q;

    for (genvar i = 0; i < N_PINS; i++) begin : g_pad
        assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_comb begin
        ack_d     = wb_cyc_i & wb_stb_i & ~ack_q;
        wr        = ack_d & wb_we_i;
        wm        = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
        wdat      = wb_data_i & wm;
        sync_d    = {sync_q[SYNC_STAGES-2:0], gpio_io};
        prev_d    = in_w;
        warm_d    = warm ? warm_q : warm_q + 3'd1;
        dir_d     = dir_q;
        out_d     = out_q;
        mode_lo_d = mode_lo_q;
        mode_hi_d = mode_hi_q;
        imask_d   = imask_q;
        w1c       = '0;

        case (wb_addr_i[5:2])
            4'd0:    rdata = dir_q;
            4'd1:    rdata = out_q;
            4'd2:    rdata = in_w;
            4'd5:    rdata = mode_lo_q;
            4'd6:    rdata = mode_hi_q;
            4'd7:    rdata = imask_q;
            4'd8:    rdata = iflag_q;
            default: rdata = '0;
        endcase

        if (wr) begin
            case (wb_addr_i[5:2])
                4'd0: dir_d     = ((dir_q & ~wm) | wdat) & PIN_MASK;
                4'd1: out_d     = ((out_q & ~wm) | wdat) & PIN_MASK;
                4'd3: out_d     = (out_q | wdat) & PIN_MASK;
                4'd4: out_d     = out_q & ~wdat;
                4'd5: mode_lo_d = ((mode_lo_q & ~wm) | wdat) & MLO_MASK;
                4'd6: mode_hi_d = ((mode_hi_q & ~wm) | wdat) & MHI_MASK;
                4'd7: imask_d   = ((imask_q & ~wm) | wdat) & PIN_MASK;
                4'd8: w1c       = wdat;
                default: ;
            endcase
        end

        // Edge modes stay quiet until the synchroniser and prev hold real pad data.
        det = '0;
        for (int i = 0; i < N_PINS; i++) begin
            case (mode_all[2*i +: 2])
                2'b00:   det[i] = ~in_w[i];
                2'b01:   det[i] = (rise[i] | fall[i]) & warm;
                2'b10:   det[i] = fall[i] & warm;
                default: det[i] = rise[i] & warm;
            endcase
        end

        // A detection in the same cycle as a W1C keeps the flag set.
        iflag_d = ((iflag_q & ~w1c) | det) & PIN_MASK;
        int_d   = |(iflag_q & imask_q);
        rdata_d = ack_d ? rdata : rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            prev_q    <= '0;
            warm_q    <= '0;
            dir_q     <= '0;
            out_q     <= '0;
            mode_lo_q <= '0;
            mode_hi_q <= '0;
            imask_q   <= '0;
            iflag_q   <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            int_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            warm_q    <= warm_d;
            dir_q     <= dir_d;
            out_q     <= out_d;
            mode_lo_q <= mode_lo_d;
            mode_hi_q <= mode_hi_d;
            imask_q   <= imask_d;
            iflag_q   <= iflag_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            int_q     <= int_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_data_o = rdata_q;
    assign int_o     = int_q;

endmodule

// File: tb/tb_gpio_irq_port.sv
// Bench for gpio_irq_port: register vectors checked through a read scoreboard,
// plus timed sequences for interrupt latency, warm-up and bus handshake.
module tb_gpio_irq_port;

    localparam logic [3:0] A_DIR = 4'd0, A_OUT = 4'd1, A_IN = 4'd2, A_SET = 4'd3, A_CLR = 4'd4;
    localparam logic [3:0] A_MLO = 4'd5, A_MHI = 4'd6, A_IMASK = 4'd7, A_IFLAG = 4'd8;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0] wb_addr_i = '0, wb_data_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_data_o, data2;
    logic        wb_ack_o, int_o, ack2, int2;
    wire  [31:0] gpio_io;
    wire  [7:0]  pads2;
    logic [31:0] tb_oe = '1, tb_val = '1;

    int n_chk = 0, n_pass = 0, sb_id = 0;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        int          id;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk_i = ~clk_i;

    for (genvar i = 0; i < 32; i++) begin : g_tbpad
        assign gpio_io[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    gpio_irq_port #(.N_PINS(32), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i),
        .wb_data_i(wb_data_i), .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o),
        .gpio_io(gpio_io), .int_o(int_o)
    );

    gpio_irq_port #(.N_PINS(8), .SYNC_STAGES(2)) dut8 (
        .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i),
        .wb_data_i(wb_data_i), .wb_data_o(data2), .wb_ack_o(ack2),
        .gpio_io(pads2), .int_o(int2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Every ack pops one scoreboard entry; reads compare the returned data.
    always @(negedge clk_i) begin
        if (!rst_i && wb_ack_o) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL ack_unexpected: got ack with empty scoreboard, expected none");
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.chk) check($sformatf("rd%0d", e.id), wb_data_o, e.exp);
            end
        end
    end

    task automatic bus(input logic we, input logic [3:0] a, input logic [3:0] sel,
                       input logic [31:0] d, input logic [31:0] exp);
        bit got;
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_addr_i = {26'h0, a, 2'b00}; wb_sel_i = sel; wb_data_i = d;
        sb.push_back('{chk: ~we, exp: exp, id: sb_id});
        sb_id++;
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clk_i); #1;
            if (wb_ack_o) got = 1'b1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        if (!got) begin
            n_chk++;
            $display("FAIL ack_timeout: got no ack in 4 cycles, expected ack for addr %0d", a);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus(1'b1, a, 4'hF, d, '0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        bus(1'b0, a, 4'hF, '0, exp);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            bus(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].data, vecs[i].exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 0..6: reset values. The synchroniser comes out of reset at 0 and every pin
        // defaults to low-level mode, so all flags latch on the first cycle.
        vecs.push_back('{1'b0, A_DIR,   4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b0, A_OUT,   4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b0, A_MLO,   4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b0, A_MHI,   4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b0, A_IMASK, 4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b0, A_IFLAG, 4'hF, 32'h0, 32'hFFFF_FFFF});
        vecs.push_back('{1'b1, A_IFLAG, 4'hF, 32'hFFFF_FFFF, 32'h0});
        // 7..26: output drive, set/clear, byte lanes, reserved and write-only reads
        vecs.push_back('{1'b0, A_IFLAG, 4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b1, A_DIR,   4'hF, 32'h0000_00FF, 32'h0});
        vecs.push_back('{1'b1, A_OUT,   4'hF, 32'h0000_00A5, 32'h0});
        vecs.push_back('{1'b0, A_OUT,   4'hF, 32'h0, 32'h0000_00A5});
        vecs.push_back('{1'b0, A_DIR,   4'hF, 32'h0, 32'h0000_00FF});
        vecs.push_back('{1'b1, A_SET,   4'hF, 32'h0000_000F, 32'h0});
        vecs.push_back('{1'b0, A_OUT,   4'hF, 32'h0, 32'h0000_00AF});
        vecs.push_back('{1'b1, A_CLR,   4'hF, 32'h0000_00A0, 32'h0});
        vecs.push_back('{1'b0, A_OUT,   4'hF, 32'h0, 32'h0000_000F});
        vecs.push_back('{1'b0, A_SET,   4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b1, A_OUT,   4'h1, 32'hFFFF_FF00, 32'h0});
        vecs.push_back('{1'b0, A_OUT,   4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b1, A_OUT,   4'hF, 32'h0000_00A5, 32'h0});
        vecs.push_back('{1'b0, 4'd12,   4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b0, A_IN,    4'hF, 32'h0, 32'hFFFF_FFA5});
        vecs.push_back('{1'b1, 4'd12,   4'hF, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 4'd12,   4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b1, A_MHI,   4'h3, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, A_MHI,   4'hF, 32'h0, 32'h0000_FFFF});
        vecs.push_back('{1'b1, A_MHI,   4'hF, 32'h0, 32'h0});
        vecs.push_back('{1'b0, A_MHI,   4'hF, 32'h0, 32'h0});

        // Reset asserted in the middle of a write that never gets acked
        cycles(3);
        rst_i = 1'b0;
        cycles(1);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
        wb_addr_i = {26'h0, A_DIR, 2'b00}; wb_data_i = 32'hFFFF_FFFF;
        #2 rst_i = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        cycles(2);
        check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        check("rst_data", wb_data_o, 32'h0);
        check("rst_int", {31'h0, int_o}, 32'h0);
        rst_i = 1'b0;
        cycles(4);
        run_vecs(0, 6);

        // Output drive: release pads 7:0 to the DUT
        tb_oe = 32'hFFFF_FF00;
        run_vecs(7, 26);
        check("pad_drive", gpio_io, 32'hFFFF_FFA5);
        check("int_quiet", {31'h0, int_o}, 32'h0);

        // Back to inputs; clear level flags picked up while pads 7:0 were driven low
        wr(A_DIR, 32'h0);
        tb_oe = '1;
        tb_val = '1;
        wr(A_MLO, 32'h0000_00C0);
        wr(A_IMASK, 32'h0000_0008);
        tb_val[3] = 1'b0;
        cycles(4);
        wr(A_IFLAG, 32'hFFFF_FFFF);
        rd(A_IFLAG, 32'h0);
        check("fall_no_int", {31'h0, int_o}, 32'h0);

        // Rising edge on pad3: flag after 3 edges, int_o one edge later
        @(posedge clk_i); #1;
        tb_val[3] = 1'b1;
        cycles(3);
        check("rise_int_lat3", {31'h0, int_o}, 32'h0);
        cycles(1);
        check("rise_int_lat4", {31'h0, int_o}, 32'h1);
        rd(A_IFLAG, 32'h0000_0008);
        wr(A_IFLAG, 32'h0000_0008);
        check("w1c_int_hold", {31'h0, int_o}, 32'h1);
        cycles(1);
        check("w1c_int_fall", {31'h0, int_o}, 32'h0);

        // Low level on pad0 keeps re-setting the flag against W1C
        wr(A_IMASK, 32'h0000_0009);
        tb_val[0] = 1'b0;
        cycles(5);
        check("lvl_int", {31'h0, int_o}, 32'h1);
        wr(A_IFLAG, 32'h0000_0001);
        rd(A_IFLAG, 32'h0000_0001);
        check("lvl_int_stays", {31'h0, int_o}, 32'h1);
        wr(A_IMASK, 32'h0);
        cycles(1);
        check("lvl_masked", {31'h0, int_o}, 32'h0);
        tb_val[0] = 1'b1;

        // Warm-up: pad5 high across reset must not look like a rising edge
        rst_i = 1'b1;
        cycles(2);
        rst_i = 1'b0;
        wr(A_MLO, 32'h0000_0C00);
        cycles(4);
        wr(A_IFLAG, 32'hFFFF_FFFF);
        cycles(4);
        rd(A_IFLAG, 32'h0);
        tb_val[5] = 1'b0;
        cycles(3);
        rd(A_IFLAG, 32'h0);
        tb_val[5] = 1'b1;
        cycles(4);
        rd(A_IFLAG, 32'h0000_0020);

        // Read held for 6 cycles: ack on cycles 1, 3, 5
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_addr_i = {26'h0, A_MLO, 2'b00};
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{chk: 1'b1, exp: 32'h0000_0C00, id: sb_id});
            sb_id++;
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk_i); #1;
            check($sformatf("hold_ack_c%0d", k), {31'h0, wb_ack_o}, {31'h0, k[0]});
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

        // Narrow build drops DIR bits at and above its pin count
        tb_oe = '0;
        wr(A_DIR, 32'hFFFF_FFFF);
        rd(A_DIR, 32'hFFFF_FFFF);
        check("dir_n8", data2, 32'h0000_00FF);

        cycles(2);
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
